// File: rtl/md_issue_ctrl.sv
// Execute-stage issue sequencer for the shared multiply/divide unit.
// Gates HI/LO instruction issue, drives the unit opcode and stalls E while an op is in flight.
module md_issue_ctrl #(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10,
    parameter int CNT_W   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        e_valid,
    input  logic [3:0]  e_md_op,
    input  logic [31:0] e_rt,
    input  logic        flush,
    input  logic        freeze,
    output logic [3:0]  md_op_out,
    output logic        stall_e,
    output logic        md_busy,
    output logic        md_done,
    output logic        div0_flag
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd5;
    localparam logic [3:0] OP_DIVU  = 4'd6;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             div0_nxt;
    logic             is_md, is_mul, is_div, issue_ok;

    always_comb begin
        is_md    = e_valid && (e_md_op inside {[4'd1:4'd8]});
        is_mul   = e_valid && (e_md_op == OP_MULT || e_md_op == OP_MULTU);
        is_div   = e_valid && (e_md_op == OP_DIV  || e_md_op == OP_DIVU);
        issue_ok = is_md && (state == IDLE) && !flush && !freeze;

        // MFHI/MFLO (7, 8) are gated by issue_ok but never sent to the unit.
        md_op_out = (issue_ok && e_md_op <= 4'd6) ? e_md_op : 4'd0;
        stall_e   = is_md && (state != IDLE) && !flush;
        md_busy   = (state != IDLE);
        md_done   = md_busy && (cnt == CNT_W'(1));
    end

    // NOTE: every signal is given a default first so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        div0_nxt  = div0_flag;
        case (state)
            IDLE: begin
                if (issue_ok && is_mul) begin
                    state_nxt = MUL_BUSY;
                    cnt_nxt   = CNT_W'(MUL_LAT);
                    div0_nxt  = 1'b0;
                end else if (issue_ok && is_div) begin
                    state_nxt = DIV_BUSY;
                    cnt_nxt   = CNT_W'(DIV_LAT);
                    div0_nxt  = (e_rt == 32'd0);
                end
            end
            default: begin
                // The unit has no abort, so flush and freeze do not hold the count.
                cnt_nxt = cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            div0_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            div0_flag <= div0_nxt;
        end
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Self-checking bench for md_issue_ctrl: directed vector table, hand sequences,
// then random stimulus against a timestamp-based reference model.
module tb_md_issue_ctrl;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset, e_valid, flush, freeze;
    logic [3:0]  e_md_op;
    logic [31:0] e_rt;
    logic [3:0]  md_op_out;
    logic        stall_e, md_busy, md_done, div0_flag;

    int n_checks = 0;
    int n_err    = 0;

    md_issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .e_valid   (e_valid),
        .e_md_op   (e_md_op),
        .e_rt      (e_rt),
        .flush     (flush),
        .freeze    (freeze),
        .md_op_out (md_op_out),
        .stall_e   (stall_e),
        .md_busy   (md_busy),
        .md_done   (md_done),
        .div0_flag (div0_flag)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: the unit is busy while cycle < free_at; issue at cycle t books it until t+1+LAT.
    int         cyc     = 0;
    int         free_at = 0;
    bit         m_div0  = 1'b0;
    logic [3:0] x_op;
    logic       x_stall, x_busy, x_done, x_div0;

    function automatic void model_eval();
        bit is_md, issue;
        is_md   = e_valid && (e_md_op inside {[4'd1:4'd8]});
        x_busy  = (cyc < free_at);
        issue   = is_md && !x_busy && !flush && !freeze;
        x_op    = (issue && e_md_op <= 4'd6) ? e_md_op : 4'd0;
        x_stall = is_md && x_busy && !flush;
        x_done  = x_busy && (cyc == free_at - 1);
        x_div0  = m_div0;
    endfunction

    function automatic void model_update();
        bit is_md, issue, is_mul, is_div;
        is_md  = e_valid && (e_md_op inside {[4'd1:4'd8]});
        is_mul = e_valid && (e_md_op inside {4'd1, 4'd2});
        is_div = e_valid && (e_md_op inside {4'd5, 4'd6});
        issue  = is_md && (cyc >= free_at) && !flush && !freeze;
        if (reset) begin
            free_at = cyc + 1;
            m_div0  = 1'b0;
        end else if (issue && is_mul) begin
            free_at = cyc + 1 + MUL_LAT;
            m_div0  = 1'b0;
        end else if (issue && is_div) begin
            free_at = cyc + 1 + DIV_LAT;
            m_div0  = (e_rt == 32'd0);
        end
        cyc++;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Apply inputs just after a rising edge, then wait for the falling edge where outputs are settled.
    task automatic drive(input bit r, input bit v, input logic [3:0] o, input logic [31:0] t,
                         input bit fl, input bit fr);
        reset   = r;
        e_valid = v;
        e_md_op = o;
        e_rt    = t;
        flush   = fl;
        freeze  = fr;
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    typedef struct {
        string       name;
        bit          valid;
        logic [3:0]  op;
        logic [31:0] rt;
        bit          flush, freeze;
        logic [3:0]  e_op;
        bit          e_stall, e_busy, e_done, e_div0;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input string name, input bit v, input logic [3:0] o,
                                input logic [31:0] t, input bit fl, input bit fr,
                                input logic [3:0] eo, input bit es, input bit eb,
                                input bit ed, input bit e0);
        vec_t x;
        x.name = name; x.valid = v; x.op = o; x.rt = t; x.flush = fl; x.freeze = fr;
        x.e_op = eo; x.e_stall = es; x.e_busy = eb; x.e_done = ed; x.e_div0 = e0;
        vecs.push_back(x);
    endfunction

    initial begin
        int n;

        // Directed table; each record is one cycle, expectations derived by hand.
        add("mult_issue", 1, 1, 3, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add($sformatf("mult_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, i == 5, 0);
        add("mfhi_idle",   1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
        add("illegal_op",  1, 12, 0, 0, 0, 0, 0, 0, 0, 0);
        add("bubble_mult", 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        add("div_flushed", 1, 5, 0, 1, 0, 0, 0, 0, 0, 0);
        add("div_rt0",     1, 5, 0, 0, 0, 5, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) add($sformatf("div_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, i == 10, 1);
        add("multu_clr",   1, 2, 7, 0, 0, 2, 0, 0, 0, 1);
        add("multu_busy1", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add("mfhi_stall",  1, 7, 0, 0, 0, 0, 1, 1, 0, 0);
        add("mthi_ffl_fz", 1, 3, 0, 1, 1, 0, 0, 1, 0, 0);
        add("mflo_flush",  1, 8, 0, 1, 0, 0, 0, 1, 0, 0);
        add("mult_done_stall", 1, 1, 9, 0, 0, 0, 1, 1, 1, 0);
        add("mult_reissue", 1, 1, 9, 0, 0, 1, 0, 0, 0, 0);
        for (int i = 1; i <= 5; i++) add($sformatf("mult2_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, i == 5, 0);
        for (int i = 1; i <= 3; i++) add($sformatf("mthi_frz%0d", i), 1, 3, 0, 0, 1, 0, 0, 0, 0, 0);
        add("mthi_go",     1, 3, 0, 0, 0, 3, 0, 0, 0, 0);
        add("after_mthi",  0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("divu_rt0",    1, 6, 0, 0, 0, 6, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) add($sformatf("divu_busy%0d", i), 0, 0, 0, 0, 0, 0, 0, 1, i == 10, 1);
        add("mtlo_keep",   1, 4, 0, 0, 0, 4, 0, 0, 0, 1);
        add("idle_keep",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

        // Reset for two cycles; outputs are undefined until the first edge.
        drive(1, 0, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0, 0);
        check("reset_busy",  md_busy,   0);
        check("reset_done",  md_done,   0);
        check("reset_stall", stall_e,   0);
        check("reset_op",    md_op_out, 0);
        check("reset_div0",  div0_flag, 0);
        tick();

        foreach (vecs[i]) begin
            drive(0, vecs[i].valid, vecs[i].op, vecs[i].rt, vecs[i].flush, vecs[i].freeze);
            check({vecs[i].name, "_op"},    md_op_out, vecs[i].e_op);
            check({vecs[i].name, "_stall"}, stall_e,   vecs[i].e_stall);
            check({vecs[i].name, "_busy"},  md_busy,   vecs[i].e_busy);
            check({vecs[i].name, "_done"},  md_done,   vecs[i].e_done);
            check({vecs[i].name, "_div0"},  div0_flag, vecs[i].e_div0);
            tick();
        end

        // DIVU followed by a held MFLO: stalled for exactly DIV_LAT cycles, then issues.
        drive(0, 1, 6, 5, 0, 0);
        check("divu_issue_op", md_op_out, 6);
        tick();
        n = 0;
        while (n < 30) begin
            drive(0, 1, 8, 0, 0, 0);
            if (stall_e !== 1'b1) break;
            n++;
            tick();
        end
        check("mflo_stall_cycles", n, DIV_LAT);
        check("mflo_issue_op",     md_op_out, 0);
        check("mflo_issue_busy",   md_busy, 0);
        check("divu_clears_div0",  div0_flag, 0);
        tick();

        // Reset in the fourth busy cycle of a DIV aborts it; MULT then issues at once.
        drive(0, 1, 5, 0, 0, 0);
        check("div_pre_rst_op", md_op_out, 5);
        tick();
        for (int i = 1; i <= 3; i++) begin
            drive(0, 0, 0, 0, 0, 0); tick();
        end
        drive(1, 0, 0, 0, 0, 0);
        check("rst_cycle_busy", md_busy, 1);
        tick();
        drive(0, 1, 1, 1, 0, 0);
        check("post_rst_busy",  md_busy,   0);
        check("post_rst_stall", stall_e,   0);
        check("post_rst_op",    md_op_out, 1);
        check("post_rst_div0",  div0_flag, 0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 0, 0);
            check($sformatf("post_rst_mult_busy%0d", i), md_busy, 1);
            check($sformatf("post_rst_mult_done%0d", i), md_done, i == 5);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0);
        check("post_rst_idle", md_busy, 0);
        tick();

        // Random stimulus checked against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 4) != 0),
                  4'($urandom_range(0, 15)),
                  ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 5) == 0));
            check("rnd_op",    md_op_out, x_op);
            check("rnd_stall", stall_e,   x_stall);
            check("rnd_busy",  md_busy,   x_busy);
            check("rnd_done",  md_done,   x_done);
            check("rnd_div0",  div0_flag, x_div0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/md_issue_ctrl.md
Name: md_issue_ctrl

Overview:
Execute-stage sequencer for the shared multiply/divide unit of the P7 pipeline. Decides each cycle whether the E-stage HI/LO instruction may issue, drives the unit's 4-bit opcode, and tracks multi-cycle latency with an internal down-counter. Generates the E-stage stall for any HI/LO access while an operation is in flight. Suppresses issue on exception/interrupt flush so a killed instruction never modifies HI/LO.

Parameters:
MUL_LAT, 5, busy cycles after a MULT/MULTU issue; must be >= 1
DIV_LAT, 10, busy cycles after a DIV/DIVU issue; must be >= 1
CNT_W, 4, counter width; must hold max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
e_valid  in  1  E-stage holds a real instruction; low for a bubble
e_md_op  in  4  decoded op: 0 none, 1 MULT, 2 MULTU, 3 MTHI, 4 MTLO, 5 DIV, 6 DIVU, 7 MFHI, 8 MFLO, others none
e_rt  in  32  forwarded RT operand; used only for the divide-by-zero flag
flush  in  1  E-stage instruction is being killed this cycle by an exception, interrupt or ERET
freeze  in  1  pipeline held by another hazard; E-stage instruction re-presents next cycle
md_op_out  out  4  opcode to the multiply/divide unit; nonzero for exactly one cycle per issue
stall_e  out  1  E-stage stall request from HI/LO contention
md_busy  out  1  high while state is MUL_BUSY or DIV_BUSY
md_done  out  1  one-cycle pulse on the last busy cycle, when HI/LO update
div0_flag  out  1  sticky; set when DIV/DIVU issues with e_rt == 0

Behaviour:
- Reset, synchronous, highest priority: state IDLE, counter 0, div0_flag 0. Combinational outputs then read md_busy 0, md_done 0, stall_e 0, md_op_out 0.
- Reset mid-operation aborts the in-flight op. The unit is reset by the same signal.
- Definitions:
  - is_md = e_valid & e_md_op in 1..8
  - is_start = e_valid & e_md_op in {1, 2, 5, 6}
  - issue_ok = is_md & state == IDLE & !flush & !freeze
- md_op_out = issue_ok & e_md_op in 1..6 ? e_md_op : 0. It is combinational. MFHI/MFLO never reach the unit.
- stall_e = is_md & state != IDLE & !flush. A flushed instruction never stalls.
- States:
  - IDLE:
    - issue_ok & op in {1, 2} -> MUL_BUSY, counter = MUL_LAT.
    - issue_ok & op in {5, 6} -> DIV_BUSY, counter = DIV_LAT.
    - MTHI/MTLO/MFHI/MFLO issue stays IDLE and costs zero busy cycles.
  - MUL_BUSY / DIV_BUSY:
    - The counter decrements every cycle, regardless of flush/freeze.
    - When counter == 1: md_done = 1 and next state is IDLE.
    - An in-flight op is never cancelled by flush; the unit has no abort.
- A dependent HI/LO instruction in E during the md_done cycle is still stalled. It issues on the following cycle in IDLE. Total occupancy is therefore LAT + 1 cycles from issue to the next issue.
- div0_flag:
  - Set on issue of DIV/DIVU with e_rt == 0. Such an op still occupies DIV_LAT cycles.
  - Cleared on any other start issue (MULT/MULTU/DIV/DIVU with nonzero RT).
  - MT*/MF* leave div0_flag unchanged.
- Simultaneous events:
  - flush and freeze together: no issue, no stall, no state change beyond the counter decrement.
  - e_valid = 0 with any e_md_op: treated as no operation.
- Unused/illegal e_md_op codes 9..15 are treated as 0.

Test Plan:
- MULT issue in IDLE, e_rt = 3 -> md_op_out = 1 for one cycle; md_busy high 5 cycles; md_done pulses in 5th busy cycle; state IDLE after.
- DIVU issue, then MFLO in E next cycle -> stall_e high 10 cycles; MFLO issues (md_op_out = 0, stall_e = 0) on cycle 11 after issue.
- DIV with flush = 1 in issue cycle -> md_op_out = 0, md_busy stays 0, div0_flag unchanged.
- DIV with e_rt = 0 -> div0_flag = 1, busy 10 cycles. Subsequent MULTU with e_rt = 7 -> div0_flag cleared at that issue.
- MTHI under freeze = 1 for 3 cycles then freeze = 0 -> md_op_out = 3 only in the first unfrozen cycle; md_busy never asserts.
- Reset asserted at busy cycle 4 of DIV -> next cycle md_busy = 0, stall_e = 0, counter 0. MULT then issues immediately.
